// File: rtl/square_voice_mixer_if.sv
// Audio FIFO side of the square voice mixer: ADC pop, DAC push, samples.
// master = mixer (pops ADC, pushes DAC); slave = FIFO/codec side.
interface square_voice_mixer_if #(
  parameter int SAMPLE_W = 32
);
  logic                audio_in_available;
  logic                audio_out_allowed;
  logic                read_audio_in;
  logic                write_audio_out;
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic [SAMPLE_W-1:0] left_out;
  logic [SAMPLE_W-1:0] right_out;

  modport master (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_in,
    input  right_in,
    output read_audio_in,
    output write_audio_out,
    output left_out,
    output right_out
  );

  modport slave (
    output audio_in_available,
    output audio_out_allowed,
    output left_in,
    output right_in,
    input  read_audio_in,
    input  write_audio_out,
    input  left_out,
    input  right_out
  );
endinterface

// File: rtl/square_voice_mixer.sv
// Multi-voice square tone generator mixed with the ADC sample into the DAC.
// Ports: CLOCK_50, reset (sync, active-high); voice_en/voice_delay/trigger/
// duration control voices; voice_active, clip status; aud = FIFO interface.
// Macro MIC_PASSTHRU_EN: when defined the ADC sample is added into the mix,
// otherwise the output carries tones only (ADC still drained).
module square_voice_mixer #(
  parameter int          NUM_VOICES = 4,
  parameter int          DELAY_W    = 19,
  parameter int          SAMPLE_W   = 32,
  parameter int unsigned AMP        = 10000000,
  parameter int          DUR_W      = 24
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [NUM_VOICES*DELAY_W-1:0] voice_delay,
  input  logic [NUM_VOICES-1:0]         trigger,
  input  logic [DUR_W-1:0]              duration,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic                          clip,
  square_voice_mixer_if.master          aud
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES + 1) + 1;

`ifdef MIC_PASSTHRU_EN
  localparam bit MIC_EN = 1'b1;
`else
  localparam bit MIC_EN = 1'b0;
`endif

  localparam logic signed [SUM_W-1:0] AMP_S = SUM_W'(AMP);
  localparam logic signed [SUM_W-1:0] MAX_S =
    {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_S =
    {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MIX,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [DUR_W-1:0]      rem_q [NUM_VOICES];
  logic [DUR_W-1:0]      rem_d [NUM_VOICES];
  logic [DELAY_W-1:0]    cnt_q [NUM_VOICES];
  logic [DELAY_W-1:0]    cnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] ph_q, ph_d;
  logic [NUM_VOICES-1:0] act;
  logic [NUM_VOICES-1:0] va_q;

  logic [SAMPLE_W-1:0] lin_q, lin_d;
  logic [SAMPLE_W-1:0] rin_q, rin_d;
  logic [SAMPLE_W-1:0] lo_q, lo_d;
  logic [SAMPLE_W-1:0] ro_q, ro_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                clip_q, clip_d;
  logic                flag_q, flag_d;

  logic signed [SUM_W-1:0] voice_sum;
  logic signed [SUM_W-1:0] mic_l, mic_r;
  logic signed [SUM_W-1:0] sum_l, sum_r;
  logic [SAMPLE_W-1:0]     sat_l, sat_r;
  logic                    clip_l, clip_r;

  // Voices: one-shot countdown, oscillator and summed contribution.
  // Inactive voices park at cnt 0 / phase 0 so each tone starts low.
  always_comb begin
    voice_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      act[i] = voice_en[i] | (rem_q[i] != '0);
      if (trigger[i]) begin
        rem_d[i] = duration;
      end else if (rem_q[i] != '0) begin
        rem_d[i] = rem_q[i] - DUR_W'(1);
      end else begin
        rem_d[i] = rem_q[i];
      end
      if (!act[i]) begin
        cnt_d[i] = '0;
        ph_d[i]  = 1'b0;
      end else if (cnt_q[i] >= voice_delay[i*DELAY_W +: DELAY_W]) begin
        cnt_d[i] = '0;
        ph_d[i]  = ~ph_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DELAY_W'(1);
        ph_d[i]  = ph_q[i];
      end
      if (act[i]) begin
        voice_sum = voice_sum + (ph_q[i] ? AMP_S : -AMP_S);
      end
    end
  end

  always_comb begin
    mic_l  = MIC_EN ? SUM_W'($signed(lin_q)) : '0;
    mic_r  = MIC_EN ? SUM_W'($signed(rin_q)) : '0;
    sum_l  = mic_l + voice_sum;
    sum_r  = mic_r + voice_sum;
    clip_l = (sum_l > MAX_S) || (sum_l < MIN_S);
    clip_r = (sum_r > MAX_S) || (sum_r < MIN_S);
    if (sum_l > MAX_S) begin
      sat_l = MAX_S[SAMPLE_W-1:0];
    end else if (sum_l < MIN_S) begin
      sat_l = MIN_S[SAMPLE_W-1:0];
    end else begin
      sat_l = sum_l[SAMPLE_W-1:0];
    end
    if (sum_r > MAX_S) begin
      sat_r = MAX_S[SAMPLE_W-1:0];
    end else if (sum_r < MIN_S) begin
      sat_r = MIN_S[SAMPLE_W-1:0];
    end else begin
      sat_r = sum_r[SAMPLE_W-1:0];
    end
  end

  // Handshake: pop ADC, register the mix, push DAC when it has room.
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    clip_d  = 1'b0;
    flag_d  = flag_q;
    lin_d   = lin_q;
    rin_d   = rin_q;
    lo_d    = lo_q;
    ro_d    = ro_q;
    unique case (state_q)
      S_IDLE: begin
        if (aud.audio_in_available && aud.audio_out_allowed) begin
          rd_d    = 1'b1;
          lin_d   = aud.left_in;
          rin_d   = aud.right_in;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        lo_d    = sat_l;
        ro_d    = sat_r;
        flag_d  = clip_l | clip_r;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (aud.audio_out_allowed) begin
          wr_d    = 1'b1;
          clip_d  = flag_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      ph_q    <= '0;
      va_q    <= '0;
      lin_q   <= '0;
      rin_q   <= '0;
      lo_q    <= '0;
      ro_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      clip_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      va_q    <= act;
      lin_q   <= lin_d;
      rin_q   <= rin_d;
      lo_q    <= lo_d;
      ro_q    <= ro_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      clip_q  <= clip_d;
      flag_q  <= flag_d;
    end
  end

  assign aud.read_audio_in   = rd_q;
  assign aud.write_audio_out = wr_q;
  assign aud.left_out        = lo_q;
  assign aud.right_out       = ro_q;
  assign voice_active        = va_q;
  assign clip                = clip_q;

endmodule

// File: tb/tb_square_voice_mixer.sv
// Self-checking bench for square_voice_mixer: voice model + sample scoreboard.
// Expected mixes are pushed at ADC pop and compared at the DAC push.
module tb_square_voice_mixer;

  localparam int          NV  = 4;
  localparam int          DW  = 19;
  localparam int          SW  = 32;
  localparam int          DUR = 24;
  localparam int unsigned AMP = 1000000000;

`ifdef MIC_PASSTHRU_EN
  localparam bit MIC = 1'b1;
`else
  localparam bit MIC = 1'b0;
`endif

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          c;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NV-1:0]    voice_en;
  logic [NV*DW-1:0] voice_delay;
  logic [NV-1:0]    trigger;
  logic [DUR-1:0]   duration;
  logic [NV-1:0]    voice_active;
  logic             clip;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_rd   = 0;
  int   n_wr   = 0;
  exp_t sb[$];

  int unsigned m_rem [NV];
  int unsigned m_cnt [NV];
  bit [NV-1:0] m_ph;

  square_voice_mixer_if #(.SAMPLE_W(SW)) aud ();

  square_voice_mixer #(
    .NUM_VOICES(NV),
    .DELAY_W   (DW),
    .SAMPLE_W  (SW),
    .AMP       (AMP),
    .DUR_W     (DUR)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .voice_en    (voice_en),
    .voice_delay (voice_delay),
    .trigger     (trigger),
    .duration    (duration),
    .voice_active(voice_active),
    .clip        (clip),
    .aud         (aud.master)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (aud.read_audio_in) n_rd <= n_rd + 1;
    if (aud.write_audio_out) n_wr <= n_wr + 1;
  end

  // Behavioural voice model, evaluated on the same edges as the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < NV; i++) begin
      if (reset) begin
        m_rem[i] <= 0;
        m_cnt[i] <= 0;
        m_ph[i]  <= 1'b0;
      end else begin
        if (voice_en[i] || m_rem[i] != 0) begin
          if (m_cnt[i] >= voice_delay[i*DW +: DW]) begin
            m_cnt[i] <= 0;
            m_ph[i]  <= ~m_ph[i];
          end else begin
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end else begin
          m_cnt[i] <= 0;
          m_ph[i]  <= 1'b0;
        end
        if (trigger[i]) m_rem[i] <= duration;
        else if (m_rem[i] != 0) m_rem[i] <= m_rem[i] - 1;
      end
    end
  end

  function automatic exp_t calc(logic [SW-1:0] l, logic [SW-1:0] r);
    longint v, sl, sr;
    exp_t   e;
    bit     cl, cr;
    v = 0;
    for (int i = 0; i < NV; i++) begin
      if (voice_en[i] || m_rem[i] != 0)
        v += m_ph[i] ? longint'(AMP) : -longint'(AMP);
    end
    sl = v + (MIC ? longint'($signed(l)) : 64'sd0);
    sr = v + (MIC ? longint'($signed(r)) : 64'sd0);
    cl = 1'b0;
    cr = 1'b0;
    if (sl > 64'sd2147483647) begin
      e.l = 32'h7FFF_FFFF; cl = 1'b1;
    end else if (sl < -64'sd2147483648) begin
      e.l = 32'h8000_0000; cl = 1'b1;
    end else begin
      e.l = sl[SW-1:0];
    end
    if (sr > 64'sd2147483647) begin
      e.r = 32'h7FFF_FFFF; cr = 1'b1;
    end else if (sr < -64'sd2147483648) begin
      e.r = 32'h8000_0000; cr = 1'b1;
    end else begin
      e.r = sr[SW-1:0];
    end
    e.c = cl | cr;
    return e;
  endfunction

  // Offer one ADC sample, push its expected mix on pop, pop on DAC push.
  task automatic run_sample(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    aud.left_in            = l;
    aud.right_in           = r;
    aud.audio_in_available = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (aud.read_audio_in) begin
        sb.push_back(calc(l, r));
        aud.audio_in_available = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (aud.write_audio_out) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (ok && sb.size() > 0) e = sb.pop_front();
    else ok = 1'b0;
    aud.audio_in_available = 1'b0;
  endtask

  task automatic test_reset();
    reset                  = 1'b1;
    voice_en               = '1;
    trigger                = '0;
    duration               = '0;
    voice_delay            = '0;
    aud.audio_in_available = 1'b1;
    aud.audio_out_allowed  = 1'b1;
    aud.left_in            = 32'h1234_5678;
    aud.right_in           = 32'h8765_4321;
    repeat (3) @(negedge clk);
    n_chk++;
    if (aud.read_audio_in !== 1'b0 || aud.write_audio_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs got rd=%b wr=%b want 0 0",
               aud.read_audio_in, aud.write_audio_out);
    end
    n_chk++;
    if (aud.left_out !== '0 || aud.right_out !== '0) begin
      n_fail++;
      $display("FAIL reset_out got %h %h want 0 0",
               aud.left_out, aud.right_out);
    end
    n_chk++;
    if (voice_active !== '0 || clip !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got va=%b clip=%b want 0 0",
               voice_active, clip);
    end
    reset                  = 1'b0;
    voice_en               = '0;
    aud.audio_in_available = 1'b0;
    @(negedge clk);
    n_chk++;
    if (voice_active !== '0 || aud.read_audio_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got va=%b rd=%b want 0 0",
               voice_active, aud.read_audio_in);
    end
  endtask

  task automatic test_tone();
    bit   ok;
    exp_t e;
    int   want;
    voice_delay = {DW'(7), DW'(5), DW'(2), DW'(3)};
    voice_en    = 4'b0001;
    @(negedge clk);
    n_chk++;
    if (voice_active !== 4'b0001) begin
      n_fail++;
      $display("FAIL tone_active got %b want 0001", voice_active);
    end
    run_sample(32'd100, 32'hFFFF_FF9C, ok, e);
    want = (MIC ? 100 : 0) - int'(AMP);
    n_chk++;
    if (!ok || aud.left_out !== want) begin
      n_fail++;
      $display("FAIL tone_low got %0d want %0d ok=%b",
               $signed(aud.left_out), want, ok);
    end
    run_sample(32'd100, 32'hFFFF_FF9C, ok, e);
    want = (MIC ? 100 : 0) + int'(AMP);
    n_chk++;
    if (!ok || aud.left_out !== want) begin
      n_fail++;
      $display("FAIL tone_high got %0d want %0d ok=%b",
               $signed(aud.left_out), want, ok);
    end
    want = (MIC ? -100 : 0) + int'(AMP);
    n_chk++;
    if (!ok || aud.right_out !== want) begin
      n_fail++;
      $display("FAIL tone_high_r got %0d want %0d",
               $signed(aud.right_out), want);
    end
  endtask

  task automatic test_back_to_back();
    bit            ok;
    exp_t          e;
    logic [SW-1:0] l, r;
    voice_en = 4'b0011;
    for (int s = 0; s < 8; s++) begin
      l = (s < 2) ? SW'(s * 1000) : SW'($urandom);
      r = (s < 2) ? -SW'(s * 777) : SW'($urandom);
      run_sample(l, r, ok, e);
      n_chk++;
      if (!ok || aud.left_out !== e.l) begin
        n_fail++;
        $display("FAIL b2b_left[%0d] got %h want %h ok=%b",
                 s, aud.left_out, e.l, ok);
      end
      n_chk++;
      if (!ok || aud.right_out !== e.r) begin
        n_fail++;
        $display("FAIL b2b_right[%0d] got %h want %h",
                 s, aud.right_out, e.r);
      end
      n_chk++;
      if (!ok || clip !== e.c) begin
        n_fail++;
        $display("FAIL b2b_clip[%0d] got %b want %b", s, clip, e.c);
      end
    end
    voice_en = '0;
  endtask

  task automatic test_oneshot();
    int cnt;
    int want;
    for (int pass = 0; pass < 3; pass++) begin
      repeat (2) @(negedge clk);
      duration = (pass == 2) ? DUR'(0) : DUR'(10);
      want     = (pass == 0) ? 10 : (pass == 1) ? 15 : 0;
      cnt      = 0;
      for (int k = 1; k <= 35; k++) begin
        trigger = (k == 1 || (pass == 1 && k == 6)) ? 4'b0010 : 4'b0000;
        @(negedge clk);
        if (voice_active[1]) cnt++;
      end
      trigger = '0;
      n_chk++;
      if (cnt !== want) begin
        n_fail++;
        $display("FAIL oneshot_len[%0d] got %0d cycles want %0d",
                 pass, cnt, want);
      end
    end
  endtask

  task automatic test_saturation();
    bit   ok;
    exp_t e;
    voice_en = '0;
    repeat (2) @(negedge clk);
    voice_delay = {NV{DW'(60)}};
    voice_en    = '1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (m_ph == '1) break;
    end
    run_sample(32'h7FFF_FFFF, 32'h0, ok, e);
    n_chk++;
    if (!ok || aud.left_out !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_pos_l got %h want 7fffffff ok=%b",
               aud.left_out, ok);
    end
    n_chk++;
    if (!ok || aud.right_out !== 32'h7FFF_FFFF || clip !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos_r got %h clip=%b want 7fffffff 1",
               aud.right_out, clip);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (m_ph == '0) break;
    end
    run_sample(32'h8000_0000, 32'h8000_0000, ok, e);
    n_chk++;
    if (!ok || aud.left_out !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sat_neg_l got %h want 80000000 ok=%b",
               aud.left_out, ok);
    end
    n_chk++;
    if (!ok || aud.right_out !== 32'h8000_0000 || clip !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg_r got %h clip=%b want 80000000 1",
               aud.right_out, clip);
    end
    n_chk++;
    if (!ok || e.l !== aud.left_out || e.c !== clip) begin
      n_fail++;
      $display("FAIL sat_model got %h/%b want %h/%b",
               aud.left_out, clip, e.l, e.c);
    end
    voice_en = '0;
  endtask

  task automatic test_stall();
    bit   ok, seen_wr;
    exp_t e;
    int   r0, w0;
    repeat (2) @(negedge clk);
    aud.audio_out_allowed  = 1'b1;
    aud.left_in            = 32'd555;
    aud.right_in           = -32'sd555;
    aud.audio_in_available = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (aud.read_audio_in) begin
        sb.push_back(calc(aud.left_in, aud.right_in));
        ok = 1'b1;
        break;
      end
    end
    r0 = n_rd;
    w0 = n_wr;
    aud.audio_out_allowed = 1'b0;
    seen_wr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (aud.write_audio_out) seen_wr = 1'b1;
    end
    n_chk++;
    if (!ok || seen_wr || n_rd !== r0 + 1) begin
      n_fail++;
      $display("FAIL stall_hold got ok=%b wr=%b reads=%0d want 1 0 %0d",
               ok, seen_wr, n_rd - r0, 1);
    end
    aud.audio_out_allowed = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (aud.write_audio_out) begin
        ok = 1'b1;
        break;
      end
    end
    aud.audio_in_available = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_chk++;
    if (!ok || aud.left_out !== e.l || aud.right_out !== e.r) begin
      n_fail++;
      $display("FAIL stall_data got %h %h want %h %h ok=%b",
               aud.left_out, aud.right_out, e.l, e.r, ok);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (n_wr !== w0 + 1 || n_rd !== r0 + 1) begin
      n_fail++;
      $display("FAIL stall_pulses got wr=%0d rd=%0d want 1 1",
               n_wr - w0, n_rd - r0);
    end
  endtask

  task automatic test_mic();
    bit   ok;
    exp_t e;
    int   r0, w0;
    voice_en = '0;
    repeat (2) @(negedge clk);
    r0 = n_rd;
    w0 = n_wr;
    run_sample(32'd12345, 32'hFFFF_FFFE, ok, e);
    n_chk++;
    if (!ok || aud.left_out !== (MIC ? 32'd12345 : 32'd0)) begin
      n_fail++;
      $display("FAIL mic_left got %0d want %0d ok=%b",
               $signed(aud.left_out), MIC ? 12345 : 0, ok);
    end
    n_chk++;
    if (!ok || aud.right_out !== (MIC ? 32'hFFFF_FFFE : 32'd0)) begin
      n_fail++;
      $display("FAIL mic_right got %0d want %0d",
               $signed(aud.right_out), MIC ? -2 : 0);
    end
    run_sample(32'd777, 32'd0, ok, e);
    repeat (2) @(negedge clk);
    n_chk++;
    if (!ok || n_rd !== r0 + 2 || n_wr !== w0 + 2) begin
      n_fail++;
      $display("FAIL mic_pacing got rd=%0d wr=%0d want 2 2",
               n_rd - r0, n_wr - w0);
    end
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_empty got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_back_to_back();
    test_oneshot();
    test_saturation();
    test_stall();
    test_mic();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/square_voice_mixer.md
Name: square_voice_mixer

Overview:
- Parametrised multi-voice square-wave tone generator and mixer, sitting between the game logic and the Audio_Controller FIFOs.
- Each voice runs in one of two modes: level-enabled (continuous tone) or triggered one-shot with a programmable duration.
- Voices are summed with the microphone sample, saturated, and written to the DAC FIFO through a registered read/write handshake FSM.

Parameters:
- NUM_VOICES, 4, number of independent tone voices (1..8).
- DELAY_W, 19, width of per-voice half-period compare value.
- SAMPLE_W, 32, audio sample width (signed two's complement).
- AMP, 10000000, per-voice square amplitude magnitude (fits in SAMPLE_W-1 bits).
- DUR_W, 24, width of one-shot duration counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- voice_en  in  NUM_VOICES  per-voice continuous enable (level)
- voice_delay  in  NUM_VOICES*DELAY_W  per-voice half-period compare value; voice i occupies bits [i*DELAY_W +: DELAY_W]
- trigger  in  NUM_VOICES  per-voice one-shot start pulse
- duration  in  DUR_W  one-shot length in clocks, sampled on trigger
- audio_in_available  in  1  ADC FIFO has a sample; left_in/right_in valid (show-ahead)
- left_in  in  SAMPLE_W  ADC left sample
- right_in  in  SAMPLE_W  ADC right sample
- audio_out_allowed  in  1  DAC FIFO has space
- read_audio_in  out  1  one-cycle pop of the ADC FIFO
- write_audio_out  out  1  one-cycle push to the DAC FIFO
- left_out  out  SAMPLE_W  mixed left sample, registered
- right_out  out  SAMPLE_W  mixed right sample, registered
- voice_active  out  NUM_VOICES  voice currently sounding
- clip  out  1  one-cycle pulse when either channel saturated on a write

Behaviour:
- Reset (synchronous, active-high, priority over all else): all outputs 0, all counters 0, all phases 0, FSM to IDLE.
- Activity: active[i] = voice_en[i] | (remaining[i] != 0). voice_active is the registered value.
- One-shot:
  - trigger[i] loads remaining[i] = duration.
  - Otherwise, while remaining[i] != 0, it decrements by 1 per clock.
  - Retrigger while busy reloads (restarts the count).
  - trigger with duration = 0 leaves the voice idle.
- Oscillator:
  - While active, cnt[i] increments every clock.
  - When cnt[i] >= delay[i]: cnt[i] <= 0 and phase[i] toggles. Half-period is delay+1 clocks.
  - The >= compare means lowering delay mid-tone wraps immediately with no 2^DELAY_W stall.
  - While inactive, cnt and phase are held at 0, so every tone starts deterministically with phase 0 (negative half).
- Contribution: active ? (phase ? +AMP : -AMP) : 0, sign-extended.
- Mix:
  - sum = input sample + sum of all contributions, computed in SAMPLE_W + $clog2(NUM_VOICES+1) + 1 bits.
  - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Left and right are mixed independently with identical voice contributions.
- Handshake FSM:
  - IDLE: if audio_in_available & audio_out_allowed, pulse read_audio_in for 1 cycle, latch left_in/right_in, go to MIX.
  - MIX: register saturated sums into left_out/right_out; set the clip flag if either channel saturated; go to WRITE.
  - WRITE: if audio_out_allowed, pulse write_audio_out for 1 cycle, pulse clip if flagged, go to IDLE. Otherwise hold in WRITE.
- Timing: the sample is written 2 cycles after its read (minimum), so throughput is 1 sample per 3 clocks, far above the 48 kHz rate.
- left_out/right_out hold their value between writes.
- Voice state is unaffected by the FSM; oscillators free-run independently of sample timing.
- trigger and voice_en both asserted: the voice stays active until voice_en deasserts and remaining reaches 0.

Optional Feature:
- Macro: MIC_PASSTHRU_EN.
- Defined: the latched left_in/right_in are added into the mix as specified above.
- Undefined: the input sample term is 0, so the output is tones only. read_audio_in is still pulsed so the ADC FIFO drains and sample pacing is unchanged.

Test Plan:
- Reset: hold reset 3 cycles with voice_en all 1 -> all outputs 0; FSM in IDLE; voice_active = 0 on the cycle after release.
- Continuous tone: NUM_VOICES=2, voice_en=2'b01, delay0=3 -> voice_active=2'b01 one cycle later. phase0 toggles every 4 clocks (period 8). Sampled output is -10000000 then +10000000 plus mic.
- One-shot: duration=10, single trigger[1] pulse -> voice_active[1] high exactly 10 cycles, then 0. Retrigger at cycle 5 extends it to 15 cycles total.
- Saturation: AMP=1000000000, 4 voices all at phase 1, left_in=0x7FFFFFFF -> left_out=0x7FFFFFFF and clip pulses with write_audio_out. All phases 0 with left_in=0x80000000 -> left_out=0x80000000.
- Handshake stall: available=1, allowed drops after read -> read pulses once; write waits in WRITE until allowed=1, then pulses once; no second read meanwhile.
- Without MIC_PASSTHRU_EN: left_in=12345, all voices idle -> left_out=0 and read_audio_in still pulses once per sample.
